// File: rtl/ballot_pkg.sv
// Shared types and constants for the voter-side ballot unit.
package ballot_pkg;

  localparam int CODE_W_DEFAULT = 4;
  localparam int N_CAND_DEFAULT = 15;

  localparam logic [CODE_W_DEFAULT-1:0] NO_VOTE = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_SELECTED = 3'd2,
    ST_SEND     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/ballot_key_enc.sv
// Combinational candidate-key encoder: one-hot key vector in, candidate code plus
// single/multiple-press flags out. Code is 0 unless exactly one key is pressed.
module ballot_key_enc
  import ballot_pkg::*;
#(
  parameter int N_CAND = N_CAND_DEFAULT,
  parameter int CODE_W = CODE_W_DEFAULT
) (
  input  logic [N_CAND-1:0] key_i,
  output logic [CODE_W-1:0] code_o,
  output logic              one_hot_o,
  output logic              multi_hot_o
);

  logic              seen;
  logic              multi;
  logic [CODE_W-1:0] code_last;

  always_comb begin
    seen      = 1'b0;
    multi     = 1'b0;
    code_last = CODE_W'(NO_VOTE);
    for (int i = 0; i < N_CAND; i++) begin
      if (key_i[i]) begin
        if (seen) multi = 1'b1;
        seen      = 1'b1;
        code_last = CODE_W'(i + 1);
      end
    end
  end

  assign one_hot_o   = seen & ~multi;
  assign multi_hot_o = multi;
  assign code_o      = one_hot_o ? code_last : CODE_W'(NO_VOTE);

endmodule

// File: rtl/ballot_unit.sv
// Voter-side ballot unit: conditions the buttons, runs the ballot FSM and sends one
// candidate code per Arm over valid/ready. Define BALLOT_DEBOUNCE_EN to add debouncing.
module ballot_unit
  import ballot_pkg::*;
#(
  parameter int N_CAND   = N_CAND_DEFAULT,
  parameter int CODE_W   = CODE_W_DEFAULT,
  parameter int TIMEOUT  = 4096,
  parameter int BEEP_CYC = 64,
  parameter int DEB_CYC  = 16
) (
  input  logic              clk,
  input  logic              Power,
  input  logic              Arm,
  input  logic [N_CAND-1:0] Key,
  input  logic              Confirm,
  input  logic              Cancel,
  input  logic              Vote_ready,
  output logic              Vote_valid,
  output logic [CODE_W-1:0] Vote_code,
  output logic              Ready_lamp,
  output logic [CODE_W-1:0] Sel_code,
  output logic              Beep,
  output logic              Err
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int BEEP_W = $clog2(BEEP_CYC + 1);

  // Two-flop synchronisers for the asynchronous button inputs.
  logic [N_CAND-1:0] key_s1_q, key_s2_q;
  logic              conf_s1_q, conf_s2_q;
  logic              canc_s1_q, canc_s2_q;

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      conf_s1_q <= 1'b0;
      conf_s2_q <= 1'b0;
      canc_s1_q <= 1'b0;
      canc_s2_q <= 1'b0;
    end else begin
      key_s1_q  <= Key;
      key_s2_q  <= key_s1_q;
      conf_s1_q <= Confirm;
      conf_s2_q <= conf_s1_q;
      canc_s1_q <= Cancel;
      canc_s2_q <= canc_s1_q;
    end
  end

  logic [N_CAND-1:0] key_c;
  logic [1:0]        btn_c;   // {cancel, confirm} after conditioning

`ifdef BALLOT_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  logic [N_CAND-1:0] key_last_q, key_stb_q;
  logic [DEB_W-1:0]  key_cnt_q;

  // The whole key vector must hold one value for DEB_CYC cycles to be taken.
  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      key_last_q <= '0;
      key_stb_q  <= '0;
      key_cnt_q  <= '0;
    end else if (key_s2_q != key_last_q) begin
      key_last_q <= key_s2_q;
      key_cnt_q  <= '0;
    end else if (key_cnt_q == DEB_W'(DEB_CYC - 1)) begin
      key_stb_q  <= key_last_q;
    end else begin
      key_cnt_q  <= key_cnt_q + 1'b1;
    end
  end
  assign key_c = key_stb_q;

  logic [1:0] btn_s2;
  assign btn_s2 = {canc_s2_q, conf_s2_q};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn_deb
    logic             last_q, stb_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge Power) begin
      if (Power) begin
        last_q <= 1'b0;
        stb_q  <= 1'b0;
        cnt_q  <= '0;
      end else if (btn_s2[gi] != last_q) begin
        last_q <= btn_s2[gi];
        cnt_q  <= '0;
      end else if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
        stb_q  <= last_q;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
    assign btn_c[gi] = stb_q;
  end
`else
  assign key_c = key_s2_q;
  assign btn_c = {canc_s2_q, conf_s2_q};
`endif

  logic [CODE_W-1:0] enc_code;
  logic              enc_one, enc_multi;

  ballot_key_enc #(
    .N_CAND (N_CAND),
    .CODE_W (CODE_W)
  ) u_key_enc (
    .key_i       (key_c),
    .code_o      (enc_code),
    .one_hot_o   (enc_one),
    .multi_hot_o (enc_multi)
  );

  // Registered event stage: button edges, key events and multi-press rising edge.
  logic              conf_prev_q, canc_prev_q, multi_prev_q;
  logic              conf_ev_q, canc_ev_q, key_ev_q, multi_ev_q;
  logic [CODE_W-1:0] key_code_q;

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      conf_prev_q  <= 1'b0;
      canc_prev_q  <= 1'b0;
      multi_prev_q <= 1'b0;
      conf_ev_q    <= 1'b0;
      canc_ev_q    <= 1'b0;
      key_ev_q     <= 1'b0;
      multi_ev_q   <= 1'b0;
      key_code_q   <= '0;
    end else begin
      conf_prev_q  <= btn_c[0];
      canc_prev_q  <= btn_c[1];
      multi_prev_q <= enc_multi;
      conf_ev_q    <= btn_c[0] & ~conf_prev_q;
      canc_ev_q    <= btn_c[1] & ~canc_prev_q;
      key_ev_q     <= enc_one;
      multi_ev_q   <= enc_multi & ~multi_prev_q;
      key_code_q   <= enc_code;
    end
  end

  state_e            state_q, state_d;
  logic [CODE_W-1:0] sel_q, sel_d;
  logic [CODE_W-1:0] vcode_q, vcode_d;
  logic              vvalid_q, vvalid_d;
  logic              beep_q, beep_d;
  logic              err_q, err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              tmo;

  assign tmo = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    vcode_d    = vcode_q;
    vvalid_d   = vvalid_q;
    beep_d     = beep_q;
    timer_d    = timer_q;
    beep_cnt_d = beep_cnt_q;
    err_d      = 1'b0;

    if (Arm && (state_q != ST_IDLE)) err_d = 1'b1;
    if (multi_ev_q && ((state_q == ST_ARMED) || (state_q == ST_SELECTED))) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (Arm) begin
          state_d = ST_ARMED;
          timer_d = '0;
        end
      end
      ST_ARMED: begin
        if (key_ev_q) begin
          state_d = ST_SELECTED;
          sel_d   = key_code_q;
          timer_d = '0;
        end else if (tmo) begin
          state_d = ST_IDLE;
          sel_d   = CODE_W'(NO_VOTE);
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SELECTED: begin
        // Confirm beats every other event, including an expiring timer.
        if (conf_ev_q) begin
          state_d  = ST_SEND;
          vcode_d  = sel_q;
          vvalid_d = 1'b1;
          timer_d  = '0;
        end else if (key_ev_q) begin
          sel_d   = key_code_q;
          timer_d = '0;
        end else if (tmo) begin
          state_d = ST_IDLE;
          sel_d   = CODE_W'(NO_VOTE);
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          if (canc_ev_q) begin
            state_d = ST_ARMED;
            sel_d   = CODE_W'(NO_VOTE);
          end
        end
      end
      ST_SEND: begin
        if (Vote_ready) begin
          state_d    = ST_DONE;
          vvalid_d   = 1'b0;
          vcode_d    = CODE_W'(NO_VOTE);
          sel_d      = CODE_W'(NO_VOTE);
          beep_d     = 1'b1;
          beep_cnt_d = '0;
        end
      end
      ST_DONE: begin
        if (beep_cnt_q == BEEP_W'(BEEP_CYC - 1)) begin
          state_d = ST_IDLE;
          beep_d  = 1'b0;
        end else begin
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = CODE_W'(NO_VOTE);
        vvalid_d = 1'b0;
        beep_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      vcode_q    <= '0;
      vvalid_q   <= 1'b0;
      beep_q     <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      beep_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      vcode_q    <= vcode_d;
      vvalid_q   <= vvalid_d;
      beep_q     <= beep_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign Vote_valid = vvalid_q;
  assign Vote_code  = vcode_q;
  assign Sel_code   = sel_q;
  assign Beep       = beep_q;
  assign Err        = err_q;
  assign Ready_lamp = (state_q == ST_ARMED) || (state_q == ST_SELECTED);

endmodule

// File: tb/tb_ballot_unit.sv
// Directed testbench for ballot_unit: vote flow, backpressure, multi-key, cancel,
// timeout, Arm while busy and reset during SEND.
module tb_ballot_unit;

  logic        clk = 1'b0;
  logic        Power;
  logic        Arm;
  logic [14:0] Key;
  logic        Confirm;
  logic        Cancel;
  logic        Vote_ready;
  logic        Vote_valid;
  logic [3:0]  Vote_code;
  logic        Ready_lamp;
  logic [3:0]  Sel_code;
  logic        Beep;
  logic        Err;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;
  int valid_seen  = 0;
  int errs        = 0;

  ballot_unit dut (
    .clk        (clk),
    .Power      (Power),
    .Arm        (Arm),
    .Key        (Key),
    .Confirm    (Confirm),
    .Cancel     (Cancel),
    .Vote_ready (Vote_ready),
    .Vote_valid (Vote_valid),
    .Vote_code  (Vote_code),
    .Ready_lamp (Ready_lamp),
    .Sel_code   (Sel_code),
    .Beep       (Beep),
    .Err        (Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Vote_valid && Vote_ready) accepted <= accepted + 1;
    if (Vote_valid) valid_seen <= valid_seen + 1;
    if (Err) errs <= errs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_arm();
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
  endtask

  task automatic press_key(input int k);
    Key    = '0;
    Key[k] = 1'b1;
    ticks(3);
    Key = '0;
    ticks(3);
  endtask

  task automatic wait_beep_done(input string tag);
    int n;
    n = 0;
    while (Beep === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check(tag, Beep, 0);
  endtask

  initial begin
    int n;
    int e0;
    int v0;
    Power = 1'b1; Arm = 1'b0; Key = '0; Confirm = 1'b0; Cancel = 1'b0; Vote_ready = 1'b0;
    ticks(3);
    check("rst_valid", Vote_valid, 0);
    check("rst_code", Vote_code, 0);
    check("rst_lamp", Ready_lamp, 0);
    check("rst_sel", Sel_code, 0);
    check("rst_beep", Beep, 0);
    check("rst_err", Err, 0);
    Power = 1'b0;
    tick();

    // 1: single vote, ready tied high
    pulse_arm();
    check("t1_lamp", Ready_lamp, 1);
    press_key(4);
    check("t1_sel", Sel_code, 5);
    Vote_ready = 1'b1;
    Confirm = 1'b1;
    ticks(3);
    check("t1_valid_early", Vote_valid, 0);
    tick();
    check("t1_valid_lat4", Vote_valid, 1);
    check("t1_code", Vote_code, 5);
    tick();
    check("t1_valid_drop", Vote_valid, 0);
    check("t1_beep_on", Beep, 1);
    check("t1_sel_clr", Sel_code, 0);
    Confirm = 1'b0;
    n = 0;
    while (Beep === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("t1_beep_len", n, 64);
    check("t1_idle_lamp", Ready_lamp, 0);
    check("t1_accepted", accepted, 1);
    Vote_ready = 1'b0;

    // 2: reselect and backpressure
    pulse_arm();
    press_key(2);
    check("t2_sel_a", Sel_code, 3);
    press_key(6);
    check("t2_sel_b", Sel_code, 7);
    Confirm = 1'b1;
    ticks(4);
    Confirm = 1'b0;
    check("t2_valid", {27'd0, Vote_valid, Vote_code}, {27'd0, 1'b1, 4'd7});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold", {27'd0, Vote_valid, Vote_code}, {27'd0, 1'b1, 4'd7});
    end
    Vote_ready = 1'b1;
    tick();
    Vote_ready = 1'b0;
    check("t2_valid_drop", Vote_valid, 0);
    check("t2_beep", Beep, 1);
    check("t2_accepted", accepted, 2);
    wait_beep_done("t2_beep_end");

    // 3: two keys together
    pulse_arm();
    e0 = errs;
    v0 = valid_seen;
    Key = 15'b000_0000_0000_1010;
    ticks(3);
    Key = '0;
    ticks(3);
    check("t3_err_count", errs - e0, 1);
    check("t3_sel", Sel_code, 0);
    check("t3_lamp", Ready_lamp, 1);
    check("t3_no_valid", valid_seen - v0, 0);

    // 4: select, cancel, confirm with nothing selected
    press_key(0);
    check("t4_sel", Sel_code, 1);
    Cancel = 1'b1;
    ticks(3);
    Cancel = 1'b0;
    ticks(3);
    check("t4_sel_cancel", Sel_code, 0);
    check("t4_lamp_cancel", Ready_lamp, 1);
    Confirm = 1'b1;
    ticks(3);
    Confirm = 1'b0;
    ticks(3);
    check("t4_valid", Vote_valid, 0);
    check("t4_sel_conf", Sel_code, 0);
    check("t4_lamp_conf", Ready_lamp, 1);

    // 5: timeout (first let the leftover ballot expire)
    n = 0;
    while (Ready_lamp === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check("t5_prev_expire", Ready_lamp, 0);
    tick();
    e0 = errs;
    v0 = valid_seen;
    pulse_arm();
    n = 0;
    while (Ready_lamp === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    check("t5_armed_len", n, 4096);
    check("t5_err_pulse", Err, 1);
    tick();
    check("t5_err_one", Err, 0);
    check("t5_err_count", errs - e0, 1);
    check("t5_no_valid", valid_seen - v0, 0);
    check("t5_sel", Sel_code, 0);

    // 6: Arm during SEND, then reset during SEND
    pulse_arm();
    press_key(8);
    check("t6_sel", Sel_code, 9);
    Confirm = 1'b1;
    ticks(4);
    Confirm = 1'b0;
    check("t6_valid", {27'd0, Vote_valid, Vote_code}, {27'd0, 1'b1, 4'd9});
    e0 = errs;
    pulse_arm();
    tick();
    check("t6_arm_err", errs - e0, 1);
    check("t6_still_valid", Vote_valid, 1);
    Vote_ready = 1'b1;
    tick();
    check("t6_valid_drop", Vote_valid, 0);
    ticks(5);
    check("t6_single_vote", accepted, 3);
    check("t6_no_revalid", Vote_valid, 0);
    Vote_ready = 1'b0;
    wait_beep_done("t6_beep_end");

    pulse_arm();
    press_key(10);
    Confirm = 1'b1;
    ticks(4);
    Confirm = 1'b0;
    check("t6_send2", {27'd0, Vote_valid, Vote_code}, {27'd0, 1'b1, 4'd11});
    #2 Power = 1'b1;
    #1;
    check("t6_pwr_valid", Vote_valid, 0);
    check("t6_pwr_sel", Sel_code, 0);
    check("t6_pwr_lamp", Ready_lamp, 0);
    tick();
    Power = 1'b0;
    tick();
    check("t6_pwr_idle", Ready_lamp, 0);
    check("t6_pwr_no_accept", accepted, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
